// File: rtl/xbar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xbar_pkg
// Description : Shared types and constants for the two-port crossbar
//               allocator: FSM state encoding and the 2-bit crossbar
//               control codes, which the crossbar datapath decodes too.
// Revision    : 1.0 - initial release
// ============================================================================
package xbar_pkg;

    // Allocator path state; encoding chosen to equal the control code.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD01 = 2'd1,
        FWD10 = 2'd2,
        BCAST = 2'd3
    } xbar_state_e;

    // Crossbar control codes.
    localparam logic [1:0] XBAR_IDLE  = 2'b00;
    localparam logic [1:0] XBAR_0TO1  = 2'b01;
    localparam logic [1:0] XBAR_1TO0  = 2'b10;
    localparam logic [1:0] XBAR_BCAST = 2'b11;

    // Control code driven to the crossbar while in a given state.
    function automatic logic [1:0] state_code(input xbar_state_e s);
        logic [1:0] code;
        code = XBAR_IDLE;
        case (s)
            FWD01:   code = XBAR_0TO1;
            FWD10:   code = XBAR_1TO0;
            BCAST:   code = XBAR_BCAST;
            default: code = XBAR_IDLE;
        endcase
        return code;
    endfunction

endpackage : xbar_pkg
`default_nettype wire

// File: rtl/xbar_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : xbar_rr_arb
// Description : Two-requester round-robin arbiter with a one-hot grant.
//               The priority register only changes when the allocator
//               releases a path, so a locked packet never disturbs it.
// Ports       : clk, rst         - clock, asynchronous active-high reset
//               req_i[1:0]       - requests (bit n = input port n)
//               rel_i            - normal release of a served packet
//               rel_port_i       - port that was just served (on rel_i)
//               flip_i           - forced release: invert priority
//               grant_o[1:0]     - one-hot grant, combinational
// Revision    : 1.0 - initial release
// ============================================================================
module xbar_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       rel_i,
    input  logic       rel_port_i,
    input  logic       flip_i,
    output logic [1:0] grant_o
);

    // 0: port 0 wins a tie, 1: port 1 wins a tie.
    logic prio_q;

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = prio_q ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (rel_i) begin
            // Point at the port that was not just served.
            prio_q <= ~rel_port_i;
        end else if (flip_i) begin
            prio_q <= ~prio_q;
        end
    end

endmodule : xbar_rr_arb
`default_nettype wire

// File: rtl/xbar_alloc.sv
`default_nettype none
// ============================================================================
// Module      : xbar_alloc
// Description : Packet-level switch allocator and flow controller for the
//               two-port crossbar. Grants input 0 (to output 1) or input 1
//               (to output 0, or broadcast), locks the path until the last
//               beat, muxes the valid/ready handshakes, and releases a
//               stalled path through a watchdog.
// Ports       : clk, rst            - clock, asynchronous active-high reset
//               in0_valid/last/ready - input port 0 handshake
//               in1_valid/last/bcast/ready - input port 1 handshake
//               out0_valid/ready     - output port 0 handshake
//               out1_valid/ready     - output port 1 handshake
//               out_last             - last flag of the routed beat
//               control_crossbar     - registered crossbar control code
//               busy                 - a path is locked
//               timeout_err          - one-cycle pulse on watchdog release
// Revision    : 1.0 - initial release
// ============================================================================
module xbar_alloc
    import xbar_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in0_valid,
    input  logic       in0_last,
    output logic       in0_ready,
    input  logic       in1_valid,
    input  logic       in1_last,
    input  logic       in1_bcast,
    output logic       in1_ready,
    output logic       out0_valid,
    input  logic       out0_ready,
    output logic       out1_valid,
    input  logic       out1_ready,
    output logic       out_last,
    output logic [1:0] control_crossbar,
    output logic       busy,
    output logic       timeout_err
);

    // A disabled watchdog still gets a 1-bit width so nothing is zero-sized.
    localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    xbar_state_e state_q;
    logic [1:0]  ctrl_q;
    logic        tmo_err_q;

    logic [1:0]  w_req;
    logic [1:0]  w_grant;
    logic        w_moved;
    logic        w_moved_last;
    logic        w_tmo_hit;

    // ------------------------------------------------------------------
    // Handshake muxing, purely a function of the locked path. In IDLE
    // every ready/valid is low so no beat can slip through before grant.
    // ------------------------------------------------------------------
    always_comb begin
        in0_ready  = 1'b0;
        in1_ready  = 1'b0;
        out0_valid = 1'b0;
        out1_valid = 1'b0;
        out_last   = 1'b0;
        w_moved    = 1'b0;
        case (state_q)
            FWD01: begin
                out1_valid = in0_valid;
                in0_ready  = out1_ready;
                out_last   = in0_last;
                w_moved    = in0_valid & out1_ready;
            end
            FWD10: begin
                out0_valid = in1_valid;
                in1_ready  = out0_ready;
                out_last   = in1_last;
                w_moved    = in1_valid & out0_ready;
            end
            BCAST: begin
                // Each sink sees valid only when the other sink is also
                // ready, so a beat is never taken by just one of them.
                in1_ready  = out0_ready & out1_ready;
                out0_valid = in1_valid & out1_ready;
                out1_valid = in1_valid & out0_ready;
                out_last   = in1_last;
                w_moved    = in1_valid & out0_ready & out1_ready;
            end
            default: begin
                w_moved    = 1'b0;
            end
        endcase
    end

    assign w_moved_last = w_moved & out_last;

    // ------------------------------------------------------------------
    // Arbiter: requests only count while no path is locked.
    // ------------------------------------------------------------------
    assign w_req = (state_q == IDLE) ? {in1_valid, in0_valid} : 2'b00;

    xbar_rr_arb u_arb (
        .clk        (clk),
        .rst        (rst),
        .req_i      (w_req),
        .rel_i      (w_moved_last),
        .rel_port_i (state_q != FWD01),
        .flip_i     (w_tmo_hit),
        .grant_o    (w_grant)
    );

    // ------------------------------------------------------------------
    // Watchdog. The counter holds the number of consecutive stalled
    // locked cycles; when it already equals the limit the path is
    // released, unless the last beat moves in that very cycle.
    // ------------------------------------------------------------------
    generate
        if (TIMEOUT_CYCLES != 0) begin : g_wdog_on
            localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
            logic [CNT_W-1:0] cnt_q;

            assign w_tmo_hit = (state_q != IDLE) && (cnt_q == c_TIMEOUT) && !w_moved_last;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else if ((state_q == IDLE) || w_moved || w_tmo_hit) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end else begin : g_wdog_off
            assign w_tmo_hit = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Path FSM with registered control code and error pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ctrl_q    <= XBAR_IDLE;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_grant[0]) begin
                        state_q <= FWD01;
                        ctrl_q  <= state_code(FWD01);
                    end else if (w_grant[1]) begin
                        // Broadcast mode is latched here and held for the
                        // whole packet regardless of later in1_bcast.
                        if (in1_bcast) begin
                            state_q <= BCAST;
                            ctrl_q  <= state_code(BCAST);
                        end else begin
                            state_q <= FWD10;
                            ctrl_q  <= state_code(FWD10);
                        end
                    end
                end
                default: begin
                    if (w_moved_last) begin
                        state_q <= IDLE;
                        ctrl_q  <= state_code(IDLE);
                    end else if (w_tmo_hit) begin
                        state_q   <= IDLE;
                        ctrl_q    <= state_code(IDLE);
                        tmo_err_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign control_crossbar = ctrl_q;
    assign busy             = (state_q != IDLE);
    assign timeout_err      = tmo_err_q;

endmodule : xbar_alloc
`default_nettype wire

// File: tb/tb_xbar_alloc.sv
`default_nettype none
// ============================================================================
// Module      : tb_xbar_alloc
// Description : Self-checking bench for xbar_alloc. Expected output beats
//               (and watchdog pulses) are queued when stimulus is issued and
//               popped by an independent monitor whenever the DUT moves a
//               beat or raises timeout_err. Directed checks cover reset,
//               stalls, idle bubbles and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xbar_alloc;
    import xbar_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in0_valid, in0_last, in0_ready;
    logic       in1_valid, in1_last, in1_bcast, in1_ready;
    logic       out0_valid, out0_ready, out1_valid, out1_ready;
    logic       out_last;
    logic [1:0] control_crossbar;
    logic       busy, timeout_err;

    always #5 clk = ~clk;

    xbar_alloc #(.TIMEOUT_CYCLES(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .in0_valid        (in0_valid),
        .in0_last         (in0_last),
        .in0_ready        (in0_ready),
        .in1_valid        (in1_valid),
        .in1_last         (in1_last),
        .in1_bcast        (in1_bcast),
        .in1_ready        (in1_ready),
        .out0_valid       (out0_valid),
        .out0_ready       (out0_ready),
        .out1_valid       (out1_valid),
        .out1_ready       (out1_ready),
        .out_last         (out_last),
        .control_crossbar (control_crossbar),
        .busy             (busy),
        .timeout_err      (timeout_err)
    );

    // One observed output event: control code, which outputs fired,
    // last flag, watchdog pulse.
    typedef struct packed {
        logic [1:0] ctrl;
        logic       o0;
        logic       o1;
        logic       last;
        logic       tmo;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    exp_t mon_act, mon_exp;
    logic mon_f0, mon_f1;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            mon_f0 = out0_valid & out0_ready;
            mon_f1 = out1_valid & out1_ready;
            if (mon_f0 || mon_f1 || timeout_err) begin
                mon_act = {control_crossbar, mon_f0, mon_f1, out_last, timeout_err};
                n_chk++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output: actual=%b required=none (ctrl,o0,o1,last,tmo)", mon_act);
                end else begin
                    mon_exp = sb_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        n_err++;
                        $display("FAIL beat_compare: actual=%b required=%b (ctrl,o0,o1,last,tmo) t=%0t",
                                 mon_act, mon_exp, $time);
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input logic v, input logic l, input logic b);
        if (port == 0) begin
            in0_valid = v;
            in0_last  = l;
        end else begin
            in1_valid = v;
            in1_last  = l;
            in1_bcast = b;
        end
    endtask

    task automatic push_pkt(input int port, input int nb, input bit bc);
        exp_t e;
        for (int b = 0; b < nb; b++) begin
            e.ctrl = (port == 0) ? 2'b01 : (bc ? 2'b11 : 2'b10);
            e.o0   = (port == 1);
            e.o1   = (port == 0) || bc;
            e.last = (b == nb - 1);
            e.tmo  = 1'b0;
            sb_q.push_back(e);
        end
    endtask

    // Sends one packet of nb beats on a port, advancing on accepted beats.
    task automatic pkt(input int port, input int nb, input bit bc);
        int   beat  = 0;
        int   guard = 0;
        logic f;
        drive(port, 1'b1, (nb == 1), bc);
        while (beat < nb) begin
            @(negedge clk);
            f = (port == 0) ? (in0_valid & in0_ready) : (in1_valid & in1_ready);
            @(posedge clk);
            #1;
            if (f) begin
                beat++;
                if (beat < nb) drive(port, 1'b1, (beat == nb - 1), bc);
            end
            guard++;
            if (guard > 100) begin
                n_chk++;
                n_err++;
                $display("FAIL pkt_stuck: port %0d beats accepted=%0d required=%0d", port, beat, nb);
                beat = nb;
            end
        end
        drive(port, 1'b0, 1'b0, 1'b0);
    endtask

    logic [1:0] trace_exp [13];

    // ---------------- stimulus ----------------
    initial begin
        trace_exp = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0,
                      2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0};
        rst        = 1'b1;
        in0_valid  = 1'b1;
        in0_last   = 1'b0;
        in1_valid  = 1'b1;
        in1_last   = 1'b0;
        in1_bcast  = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;

        // Reset: requests present, but everything must stay quiet.
        @(posedge clk);
        #2;
        check("rst_ctrl", 32'(control_crossbar), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hs", 32'({in0_ready, in1_ready, out0_valid, out1_valid, timeout_err}), 32'd0);
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Contention right after reset: p0, p1, p0, p1 with idle bubbles.
        push_pkt(0, 2, 0);
        push_pkt(1, 2, 0);
        push_pkt(0, 2, 0);
        push_pkt(1, 2, 0);
        fork
            begin
                pkt(0, 2, 0);
                pkt(0, 2, 0);
            end
            begin
                pkt(1, 2, 0);
                pkt(1, 2, 0);
            end
            begin
                for (int i = 0; i < 13; i++) begin
                    @(negedge clk);
                    check($sformatf("rr_trace[%0d]", i), 32'(control_crossbar), 32'(trace_exp[i]));
                end
            end
        join
        tick();

        // Single 3-beat packet on port 0.
        push_pkt(0, 3, 0);
        pkt(0, 3, 0);
        @(negedge clk);
        check("p0_release_ctrl", 32'(control_crossbar), 32'd0);
        check("p0_release_busy", 32'(busy), 32'd0);
        tick();

        // Broadcast with out1 stalled for two cycles.
        push_pkt(1, 1, 1);
        out1_ready = 1'b0;
        drive(1, 1'b1, 1'b1, 1'b1);
        tick();
        in1_bcast = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("bc_stall_ctrl", 32'(control_crossbar), 32'd3);
            check("bc_stall_hs", 32'({in1_ready, out0_valid, out1_valid}), 32'b001);
            tick();
        end
        out1_ready = 1'b1;
        @(negedge clk);
        check("bc_go_hs", 32'({in1_ready, out0_valid, out1_valid}), 32'b111);
        tick();
        drive(1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("bc_release_ctrl", 32'(control_crossbar), 32'd0);
        tick();

        // Watchdog: port 0 granted, then its valid drops.
        sb_q.push_back({2'b00, 1'b0, 1'b0, 1'b0, 1'b1});
        drive(0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check($sformatf("wd_hold[%0d]", i), 32'({control_crossbar, timeout_err}), 32'b010);
            tick();
        end
        @(negedge clk);
        check("wd_fire", 32'({control_crossbar, timeout_err, busy}), 32'b0010);
        tick();
        @(negedge clk);
        check("wd_pulse_end", 32'(timeout_err), 32'd0);
        tick();
        // Priority now favours port 1.
        push_pkt(1, 1, 0);
        push_pkt(0, 1, 0);
        fork
            pkt(1, 1, 0);
            pkt(0, 1, 0);
        join
        tick();

        // Asynchronous reset in the middle of a FWD10 packet.
        out0_ready = 1'b0;
        drive(1, 1'b1, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        check("ar_pre_ctrl", 32'(control_crossbar), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("ar_ctrl", 32'(control_crossbar), 32'd0);
        check("ar_hs", 32'({in0_ready, in1_ready, out0_valid, out1_valid, busy}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ar_idle_ctrl", 32'(control_crossbar), 32'd0);
        tick();
        @(negedge clk);
        check("ar_regrant_ctrl", 32'(control_crossbar), 32'd2);
        tick();
        push_pkt(1, 1, 0);
        in1_last   = 1'b1;
        out0_ready = 1'b1;
        tick();
        drive(1, 1'b0, 1'b0, 1'b0);
        tick();

        // Last beat moves exactly when the stall counter reaches the limit.
        out1_ready = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) tick();
        push_pkt(0, 1, 0);
        in0_last   = 1'b1;
        out1_ready = 1'b1;
        @(negedge clk);
        check("prec_ctrl", 32'(control_crossbar), 32'd1);
        tick();
        drive(0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("prec_no_err", 32'({control_crossbar, timeout_err}), 32'd0);
        tick();
        @(negedge clk);
        check("prec_no_err_late", 32'(timeout_err), 32'd0);

        repeat (3) tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // Global bound in case anything above stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err + 1);
        $fatal(1);
    end

endmodule : tb_xbar_alloc
`default_nettype wire
